// File: rtl/bus_pkg.sv
// bus_pkg: FSM encoding and default destination-ID constants shared by the bus arbiter slice.
package bus_pkg;
    typedef enum logic [1:0] {IDLE, ROUTE, WAIT} state_t;
    localparam int DEF_ID_W = 8;
    localparam logic [DEF_ID_W-1:0] DEF_BROADCAST = '1;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, searching upward from last_grant+1 with wrap-around.
module rr_arbiter #(
    parameter int DRVRS = 4
) (
    input  logic [DRVRS-1:0]         req,
    input  logic [$clog2(DRVRS)-1:0] last_grant,
    output logic                     gnt_valid,
    output logic [$clog2(DRVRS)-1:0] gnt_idx
);
    // Walk from the farthest candidate inward so the nearest requester is the final assignment.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx = '0;
        for (int k = DRVRS; k >= 1; k--) begin
            if (req[(int'(last_grant) + k) % DRVRS]) begin
                gnt_valid = 1'b1;
                gnt_idx = $clog2(DRVRS)'((int'(last_grant) + k) % DRVRS);
            end
        end
    end
endmodule

// File: rtl/bus_rr_arbiter.sv
// bus_rr_arbiter: round-robin shared-bus router; pops one packet, decodes its destination
// (unicast, loopback or broadcast) and pushes it all-or-nothing once every target has room.
module bus_rr_arbiter
    import bus_pkg::*;
#(
    parameter int DRVRS = 4,
    parameter int PCKG_SZ = 16,
    parameter int ID_W = DEF_ID_W,
    parameter logic [ID_W-1:0] BROADCAST = {ID_W{1'b1}}
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DRVRS-1:0]           pndng,
    input  logic [DRVRS*PCKG_SZ-1:0]   D_pop,
    output logic [DRVRS-1:0]           pop,
    input  logic [DRVRS-1:0]           full,
    output logic [DRVRS-1:0]           push,
    output logic [PCKG_SZ-1:0]         D_push,
    output logic [15:0]                drop_cnt,
    output logic                       busy
);
    localparam int IW = $clog2(DRVRS);
    state_t state, state_d;
    logic [PCKG_SZ-1:0] data_q;
    logic [IW-1:0] src_q, last_grant, gnt_idx;
    logic [DRVRS-1:0] mask_q, route_mask, mask;
    logic [ID_W-1:0] dest;
    logic gnt_valid, can_push;
    rr_arbiter #(.DRVRS(DRVRS)) u_rr (
        .req(pndng),
        .last_grant(last_grant),
        .gnt_valid(gnt_valid),
        .gnt_idx(gnt_idx)
    );
    // An empty route mask marks a destination that cannot be delivered.
    always_comb begin
        dest = data_q[PCKG_SZ-1 -: ID_W];
        route_mask = (dest == BROADCAST) ? ~(DRVRS'(1) << src_q) :
                     (64'(dest) < 64'(DRVRS)) ? DRVRS'(1) << dest : '0;
        mask = (state == ROUTE) ? route_mask : mask_q;
        can_push = (state != IDLE) && (|mask) && !(|(full & mask));
        state_d = (state == IDLE) ? (gnt_valid ? ROUTE : IDLE) :
                  (can_push || mask == '0) ? IDLE : WAIT;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy <= 1'b0;
            pop <= '0;
            push <= '0;
            D_push <= '0;
            data_q <= '0;
            src_q <= '0;
            mask_q <= '0;
            drop_cnt <= '0;
            last_grant <= IW'(DRVRS - 1);
        end else begin
            state <= state_d;
            busy <= state_d != IDLE;
            pop <= '0;
            push <= '0;
            if (state == IDLE && gnt_valid) begin
                data_q <= D_pop[int'(gnt_idx)*PCKG_SZ +: PCKG_SZ];
                src_q <= gnt_idx;
                last_grant <= gnt_idx;
                pop <= DRVRS'(1) << gnt_idx;
            end
            if (state == ROUTE) begin
                mask_q <= route_mask;
                if (route_mask == '0 && drop_cnt != 16'hFFFF)
                    drop_cnt <= drop_cnt + 16'd1;
            end
            if (can_push) begin
                push <= mask;
                D_push <= data_q;
            end
        end
    end
endmodule
